dsm_rx_ddc: RTL and testbench

Receive-path digital downconverter for one beamformer channel. It takes the 2-bit ternary delta-sigma bitstream from the channel ADC and mixes it to baseband with the fs/4 LO (I: +1,0,-1,0; Q: 0,+1,0,-1). It then decimates each branch with a 3rd-order CIC (differential delay 1). The outputs are 15-bit signed I/Q samples with a valid strobe, suitable for the receive phase-shift/combining stage.

---
 rtl/dsm_rx_ddc.sv | 111 +++++++++++
 tb/tb_dsm_rx_ddc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dsm_rx_ddc.sv
// Receive-path DDC: ternary DSM bitstream mixed to baseband by an fs/4 LO, then decimated
// per I/Q branch by a 3rd-order CIC (R = 2^DEC_LOG2, differential delay 1).
module dsm_rx_ddc #(
  parameter int unsigned DEC_LOG2 = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         pwm_in,
  output logic signed [14:0] dout_i,
  output logic signed [14:0] dout_q,
  output logic               dout_valid,
  output logic               code_err
);

  localparam int unsigned ACC_W = 3 * DEC_LOG2 + 2;

  logic [1:0]              lo_cnt;
  logic [DEC_LOG2-1:0]     dec_cnt;
  logic                    strike;

  logic signed [1:0]       d;
  logic signed [1:0]       mix_i;
  logic signed [1:0]       mix_q;
  logic signed [1:0]       x     [2];
  logic signed [ACC_W-1:0] x_ext [2];

  logic signed [ACC_W-1:0] int1  [2];
  logic signed [ACC_W-1:0] int2  [2];
  logic signed [ACC_W-1:0] int3  [2];
  logic signed [ACC_W-1:0] z1    [2];
  logic signed [ACC_W-1:0] z2    [2];
  logic signed [ACC_W-1:0] z3    [2];
  logic signed [ACC_W-1:0] c1    [2];
  logic signed [ACC_W-1:0] c2    [2];
  logic signed [ACC_W-1:0] c3    [2];

  // The illegal code 2'b11 decodes to zero; it is only flagged via code_err.
  always_comb begin
    d = '0;
    case (pwm_in)
      2'b01:   d = 2'sd1;
      2'b10:   d = -2'sd1;
      default: d = '0;
    endcase
  end

  // I LO = {+1,0,-1,0}, Q LO = {0,+1,0,-1}; d is never -2 so negation cannot overflow.
  always_comb begin
    mix_i = '0;
    mix_q = '0;
    case (lo_cnt)
      2'd0:    mix_i = d;
      2'd1:    mix_q = d;
      2'd2:    mix_i = -d;
      default: mix_q = -d;
    endcase
  end

  assign strike = &dec_cnt;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      x_ext[b] = {{(ACC_W - 2){x[b][1]}}, x[b]};
      c1[b]    = int3[b] - z1[b];
      c2[b]    = c1[b] - z2[b];
      c3[b]    = c2[b] - z3[b];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lo_cnt     <= '0;
      dec_cnt    <= '0;
      code_err   <= 1'b0;
      dout_valid <= 1'b0;
      dout_i     <= '0;
      dout_q     <= '0;
      for (int b = 0; b < 2; b++) begin
        x[b]    <= '0;
        int1[b] <= '0;
        int2[b] <= '0;
        int3[b] <= '0;
        z1[b]   <= '0;
        z2[b]   <= '0;
        z3[b]   <= '0;
      end
    end else begin
      lo_cnt     <= lo_cnt + 2'd1;
      dec_cnt    <= dec_cnt + 1'b1;
      code_err   <= (pwm_in == 2'b11);
      dout_valid <= strike;
      x[0]       <= mix_i;
      x[1]       <= mix_q;
      for (int b = 0; b < 2; b++) begin
        int1[b] <= int1[b] + x_ext[b];
        int2[b] <= int2[b] + int1[b];
        int3[b] <= int3[b] + int2[b];
      end
      if (strike) begin
        for (int b = 0; b < 2; b++) begin
          z1[b] <= int3[b];
          z2[b] <= c1[b];
          z3[b] <= c2[b];
        end
        dout_i <= {{(15 - ACC_W){c3[0][ACC_W-1]}}, c3[0]};
        dout_q <= {{(15 - ACC_W){c3[1][ACC_W-1]}}, c3[1]};
      end
    end
  end

endmodule

// File: tb/tb_dsm_rx_ddc.sv
// Self-checking bench for dsm_rx_ddc: per-window expected I/Q values are queued as stimulus
// is driven and popped on each dout_valid strobe.
module tb_dsm_rx_ddc;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         pwm_in = 2'b00;
  logic signed [14:0] dout_i;
  logic signed [14:0] dout_q;
  logic               dout_valid;
  logic               code_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit                 chk;
    logic signed [14:0] i;
    logic signed [14:0] q;
  } exp_t;

  exp_t sb[$];

  // Codes for LO phase 0..3 packed low-to-high, two bits each.
  localparam logic [7:0] TONE_I   = 8'b00_10_00_01;
  localparam logic [7:0] TONE_Q   = 8'b10_00_01_00;
  localparam logic [7:0] TONE_INV = 8'b00_01_00_10;
  localparam logic [7:0] DC_POS   = 8'b01_01_01_01;
  localparam logic [7:0] ZERO     = 8'b00_00_00_00;

  always #5 clock = ~clock;

  dsm_rx_ddc #(.DEC_LOG2(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .dout_i     (dout_i),
    .dout_q     (dout_q),
    .dout_valid (dout_valid),
    .code_err   (code_err)
  );

  task automatic drive_edge(input logic [1:0] code);
    pwm_in = code;
    @(posedge clock);
    #1;
  endtask

  task automatic hold_reset;
    reset  = 1'b1;
    pwm_in = 2'b00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    pwm_in = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (dout_i !== 15'sd0) begin
      n_fail++;
      $display("FAIL reset_dout_i: got %0d want 0", dout_i);
    end
    n_tests++;
    if (dout_q !== 15'sd0) begin
      n_fail++;
      $display("FAIL reset_dout_q: got %0d want 0", dout_q);
    end
    n_tests++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", dout_valid);
    end
    n_tests++;
    if (code_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_code_err: got %b want 0", code_err);
    end
  endtask

  // Drives windows*R edges of a periodic pattern; bad_edge >= 0 replaces that edge's code
  // with 2'b11 and excuses the 4 windows it can disturb.
  task automatic test_stream(input string name, input logic [7:0] pat,
                             input logic signed [14:0] ei, input logic signed [14:0] eq,
                             input int windows, input int first_chk, input int bad_edge,
                             input bit skip_reset);
    exp_t       e;
    exp_t       got;
    logic [1:0] code;
    int         k;
    if (!skip_reset) hold_reset();
    sb.delete();
    for (int w = 0; w < windows; w++) begin
      e.chk = (w >= first_chk) &&
              !(bad_edge >= 0 && w >= bad_edge / 8 && w <= bad_edge / 8 + 3);
      e.i   = ei;
      e.q   = eq;
      sb.push_back(e);
      for (int s = 0; s < 8; s++) begin
        k    = w * 8 + s;
        code = (k == bad_edge) ? 2'b11 : pat[2 * (k % 4) +: 2];
        drive_edge(code);
        n_tests++;
        if (dout_valid !== (s == 7)) begin
          n_fail++;
          $display("FAIL %s valid edge %0d: got %b want %b", name, k + 1, dout_valid, (s == 7));
        end
        n_tests++;
        if (code_err !== (k == bad_edge)) begin
          n_fail++;
          $display("FAIL %s code_err edge %0d: got %b want %b", name, k + 1, code_err,
                   (k == bad_edge));
        end
        if (dout_valid === 1'b1) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s unexpected valid edge %0d: got valid want none", name, k + 1);
          end else begin
            got = sb.pop_front();
            if (got.chk) begin
              n_tests++;
              if (dout_i !== got.i || dout_q !== got.q) begin
                n_fail++;
                $display("FAIL %s window %0d: got I=%0d Q=%0d want I=%0d Q=%0d", name, w + 1,
                         dout_i, dout_q, got.i, got.q);
              end
            end
          end
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: got %0d pending want 0", name, sb.size());
    end
  endtask

  task automatic test_reset_mid;
    test_stream("pre_reset", TONE_I, 15'sd256, 15'sd0, 5, 3, -1, 1'b0);
    n_tests++;
    if (dout_valid !== 1'b1 || dout_i !== 15'sd256) begin
      n_fail++;
      $display("FAIL pre_reset_state: got valid=%b I=%0d want valid=1 I=256", dout_valid,
               dout_i);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (dout_i !== 15'sd0 || dout_q !== 15'sd0 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got I=%0d Q=%0d valid=%b want 0 0 0", dout_i, dout_q,
               dout_valid);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    test_stream("post_reset", TONE_I, 15'sd256, 15'sd0, 8, 3, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_stream("idle", ZERO, 15'sd0, 15'sd0, 6, 0, -1, 1'b0);
    test_stream("tone_i", TONE_I, 15'sd256, 15'sd0, 8, 3, -1, 1'b0);
    test_stream("tone_q", TONE_Q, 15'sd0, 15'sd256, 8, 3, -1, 1'b0);
    test_stream("tone_inv", TONE_INV, -15'sd256, 15'sd0, 8, 3, -1, 1'b0);
    test_stream("dc_null", DC_POS, 15'sd0, 15'sd0, 8, 3, -1, 1'b0);
    test_stream("code_err", TONE_I, 15'sd256, 15'sd0, 14, 3, 40, 1'b0);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
